// File: rtl/regread_pkg.sv
// Shared types and sizes for the register-read sequencer.
package regread_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } rr_state_t;

  localparam int NREGS  = 32;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr, and ptr moves past the winner on each accept.
module rr_arbiter
  import regread_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
    end
  end

endmodule

// File: rtl/regread_sequencer.sv
// Shares one 32-entry register-read mux among NREQ requesters: accept, hold the
// select for SETTLE cycles while the mux tree settles, capture, respond.
module regread_sequencer
  import regread_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]      mux_sel,
  input  logic [DATA_W-1:0]      mux_data,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   busy
);

  if (SETTLE < 1) begin : g_bad_settle
    $error("regread_sequencer: SETTLE must be at least 1");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("regread_sequencer: NREQ must be in 2..8");
  end

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  rr_state_t         state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [NREQ-1:0]   owner;
  logic [NREQ-1:0]   grant;
  logic [ADDR_W-1:0] grant_addr;
  logic              accept;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_addr = grant_addr | req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    busy      = 1'b0;
    accept    = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          req_ready = grant;
          accept    = |grant;
          if (accept) state_nxt = WAIT;
        end
        WAIT: begin
          busy = 1'b1;
          if (cnt == '0) state_nxt = RESP;
        end
        RESP: begin
          rsp_valid = owner;
          req_ready = grant;
          accept    = |grant;
          state_nxt = accept ? WAIT : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= '0;
      mux_sel  <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mux_sel <= grant_addr;
        owner   <= grant;
        cnt     <= CW'(SETTLE - 1);
      end else if (state == WAIT) begin
        // mux_sel has been stable for SETTLE full cycles when cnt reaches 0
        if (cnt == '0) rsp_data <= mux_data;
        else           cnt      <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regread_sequencer.sv
// Directed bench: SETTLE=2 instance for the main scenarios, SETTLE=1 instance for short latency.
module tb_regread_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [3:0]  req_ready;
  logic [4:0]  mux_sel;
  logic [63:0] mux_data;
  logic [3:0]  rsp_valid;
  logic [63:0] rsp_data;
  logic        busy;

  logic        reset1;
  logic [3:0]  req_valid1;
  logic [19:0] req_addr1;
  logic [3:0]  req_ready1;
  logic [4:0]  mux_sel1;
  logic [63:0] mux_data1;
  logic [3:0]  rsp_valid1;
  logic [63:0] rsp_data1;
  logic        busy1;

  int errors = 0;
  int checks = 0;
  int gs[5] = '{0, 1, 2, 3, 0};

  // Register file contents as seen at the mux output; index 31 is XZR.
  function automatic logic [63:0] mdl(input logic [4:0] a);
    if (a == 5'd5)       return 64'hA5;
    else if (a == 5'd31) return 64'h0;
    else return 64'h1000_0000_0000_0000 | {27'd0, a, 32'd0} | {59'd0, a};
  endfunction

  assign mux_data  = mdl(mux_sel);
  assign mux_data1 = mdl(mux_sel1);

  regread_sequencer #(.NREQ(4), .SETTLE(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .mux_sel(mux_sel), .mux_data(mux_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  regread_sequencer #(.NREQ(4), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset1), .req_valid(req_valid1), .req_addr(req_addr1),
    .req_ready(req_ready1), .mux_sel(mux_sel1), .mux_data(mux_data1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [4:0] a);
    req_addr[i*5 +: 5] = a;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0;
    reset1 = 1'b1; req_valid1 = '0; req_addr1 = '0;
    tick(); tick();
    req_valid = 4'hF; #1;
    chk("ready_in_reset", 64'(req_ready), 64'h0);
    chk("rsp_in_reset", 64'(rsp_valid), 64'h0);
    req_valid = '0; reset = 1'b0; reset1 = 1'b0;
    chk("rst_mux_sel", 64'(mux_sel), 64'h0);
    chk("rst_rsp_data", rsp_data, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);

    // single request, requester 1, addr 5
    tick();
    set_addr(1, 5); req_valid = 4'b0010; #1;
    chk("s1_ready", 64'(req_ready), 64'h2);
    tick(); req_valid = '0; #1;
    chk("s1_mux_sel", 64'(mux_sel), 64'd5);
    chk("s1_busy_w1", 64'(busy), 64'h1);
    chk("s1_ready_wait", 64'(req_ready), 64'h0);
    tick(); #1;
    chk("s1_busy_w2", 64'(busy), 64'h1);
    tick(); #1;
    chk("s1_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("s1_rsp_data", rsp_data, 64'hA5);
    chk("s1_busy_resp", 64'(busy), 64'h0);
    tick(); #1;
    chk("s1_rsp_clear", 64'(rsp_valid), 64'h0);
    chk("s1_data_hold", rsp_data, 64'hA5);

    // contention from reset: grants 0,1,2,3,0 every 3 cycles
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) set_addr(i, 5'(8 + i));
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("cont_ready", 64'(req_ready), 64'(1 << gs[i]));
      tick(); #1;
      chk("cont_busy1", 64'(busy), 64'h1);
      tick(); #1;
      chk("cont_busy2", 64'(busy), 64'h1);
      tick(); #1;
      chk("cont_rsp_valid", 64'(rsp_valid), 64'(1 << gs[i]));
      chk("cont_rsp_data", rsp_data, mdl(5'(8 + gs[i])));
    end
    req_valid = '0;
    tick();

    // fairness: 0 always requesting, 2 requests once
    set_addr(0, 3); req_valid = 4'b0001; #1;
    chk("fair_ready0", 64'(req_ready), 64'h1);
    tick();
    set_addr(2, 7); req_valid = 4'b0101; #1;
    chk("fair_ready_wait", 64'(req_ready), 64'h0);
    tick(); tick(); #1;
    chk("fair_rsp0", 64'(rsp_valid), 64'h1);
    chk("fair_data0", rsp_data, mdl(5'd3));
    chk("fair_ready2", 64'(req_ready), 64'h4);
    tick(); req_valid = 4'b0001; #1;
    chk("fair_busy", 64'(busy), 64'h1);
    tick(); tick(); #1;
    chk("fair_rsp2", 64'(rsp_valid), 64'h4);
    chk("fair_data2", rsp_data, mdl(5'd7));
    chk("fair_ready0b", 64'(req_ready), 64'h1);
    tick(); req_valid = '0;
    tick(); tick(); #1;
    chk("fair_rsp0b", 64'(rsp_valid), 64'h1);
    tick();

    // back-to-back on requester 3: addrs 0, 31, 17
    set_addr(3, 0); req_valid = 4'b1000; #1;
    chk("b2b_ready_a", 64'(req_ready), 64'h8);
    tick(); set_addr(3, 31); #1;
    chk("b2b_sel_a", 64'(mux_sel), 64'd0);
    tick(); tick(); #1;
    chk("b2b_rsp_a", 64'(rsp_valid), 64'h8);
    chk("b2b_data_a", rsp_data, mdl(5'd0));
    chk("b2b_ready_b", 64'(req_ready), 64'h8);
    tick(); set_addr(3, 17); #1;
    chk("b2b_sel_b", 64'(mux_sel), 64'd31);
    tick(); tick(); #1;
    chk("b2b_rsp_b", 64'(rsp_valid), 64'h8);
    chk("b2b_data_xzr", rsp_data, 64'h0);
    chk("b2b_ready_c", 64'(req_ready), 64'h8);
    tick(); req_valid = '0; #1;
    chk("b2b_sel_c", 64'(mux_sel), 64'd17);
    tick(); tick(); #1;
    chk("b2b_rsp_c", 64'(rsp_valid), 64'h8);
    chk("b2b_data_c", rsp_data, mdl(5'd17));
    chk("b2b_ready_none", 64'(req_ready), 64'h0);
    tick();

    // reset in the middle of WAIT
    set_addr(2, 5); req_valid = 4'b0100; #1;
    chk("rw_ready", 64'(req_ready), 64'h4);
    tick(); req_valid = '0; reset = 1'b1; #1;
    chk("rw_ready_rst", 64'(req_ready), 64'h0);
    chk("rw_rsp_rst", 64'(rsp_valid), 64'h0);
    tick(); reset = 1'b0; #1;
    chk("rw_busy", 64'(busy), 64'h0);
    chk("rw_mux_sel", 64'(mux_sel), 64'h0);
    chk("rw_rsp_data", rsp_data, 64'h0);
    chk("rw_rsp0", 64'(rsp_valid), 64'h0);
    tick(); #1;
    chk("rw_rsp1", 64'(rsp_valid), 64'h0);
    tick(); #1;
    chk("rw_rsp2", 64'(rsp_valid), 64'h0);
    req_valid = 4'hF; #1;
    chk("rw_ptr_zero", 64'(req_ready), 64'h1);
    req_valid = '0;

    // SETTLE=1: response two cycles after accept
    req_addr1[4:0] = 5'd9; req_valid1 = 4'b0001; #1;
    chk("s1b_ready", 64'(req_ready1), 64'h1);
    tick(); req_valid1 = '0; req_addr1[4:0] = 5'd20; #1;
    chk("s1b_sel", 64'(mux_sel1), 64'd9);
    chk("s1b_busy", 64'(busy1), 64'h1);
    tick(); #1;
    chk("s1b_rsp", 64'(rsp_valid1), 64'h1);
    chk("s1b_data", rsp_data1, mdl(5'd9));
    req_valid1 = 4'b0001; #1;
    chk("s1b_ready2", 64'(req_ready1), 64'h1);
    tick(); req_valid1 = '0; #1;
    chk("s1b_sel2", 64'(mux_sel1), 64'd20);
    tick(); #1;
    chk("s1b_rsp2", 64'(rsp_valid1), 64'h1);
    chk("s1b_data2", rsp_data1, mdl(5'd20));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regread_sequencer.md
# regread_sequencer

Sequencer and round-robin arbiter that shares one 64-bit, 32-entry register-read mux among `NREQ` requesters (decode read ports, debug/scan port, test harness). It accepts one read request at a time via valid/ready and drives the mux select from a register. It holds the select stable for `SETTLE` cycles so the gate-level mux tree (five 2:1 levels of 50 ps gates) settles, then captures the mux output and returns it to the granted requester. It sits between the register-file storage/mux and the pipeline front end.

## Interface
Parameters:
- `NREQ`, 4: number of requesters; legal range 2..8.
- `SETTLE`, 2: cycles `mux_sel` is held stable before capture; must be ≥1 (elaboration-time check fails on 0).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester read request.
- `req_addr`  in  NREQ×5  per-requester register index 0..31.
- `req_ready`  out  NREQ  one-hot accept; request transfers when `req_valid[i] && req_ready[i]`.
- `mux_sel`  out  5  registered select to the 32:1×64 mux.
- `mux_data`  in  64  mux output.
- `rsp_valid`  out  NREQ  one-hot, one-cycle response strobe.
- `rsp_data`  out  64  captured read data, valid when any `rsp_valid` bit is high.
- `busy`  out  1  high in WAIT state.

## Operation
- States: IDLE, WAIT, RESP.
- Accepting states are IDLE and RESP.
  - If any `req_valid` is high, the arbiter picks a winner `g` round-robin.
  - `req_ready[g]` = 1, combinational, same cycle.
  - Next edge: `mux_sel` ← `req_addr[g]`, `owner` ← `g`, counter ← `SETTLE-1`, state → WAIT.
  - Otherwise RESP → IDLE and IDLE stays.
- WAIT: counter decrements each cycle. When the counter is 0: `rsp_data` ← `mux_data`, state → RESP.
- RESP: `rsp_valid[owner]` = 1 for exactly this cycle. A new accept in RESP is allowed, giving back-to-back operation.
- Round-robin: pointer `ptr` is set to `(g+1) mod NREQ` on every accept. Search order is `ptr`, `ptr+1`, … wrapping. Reset value of `ptr` is 0.
- Requesters must hold `req_valid` and `req_addr` stable until accepted. Deasserting before accept is legal and simply withdraws the request.
- `req_ready` is all-zero in WAIT and while `reset` is high.
- `mux_sel` holds its last value in IDLE; it changes only on accept.
- Index 31 needs no special handling; the register file supplies XZR = 0 at that mux input.
- Reset mid-operation: state → IDLE, any in-flight request is dropped, and no `rsp_valid` is issued.
- Reset values: `mux_sel`=0, `rsp_data`=0, `rsp_valid`=0, `req_ready`=0, `busy`=0, `ptr`=0.

## Timing
- Accept in cycle T. `mux_sel` is new from T+1. Capture happens at the end of cycle T+SETTLE. `rsp_valid` is high in cycle T+SETTLE+1.
- Latency from accept to response: SETTLE+1 cycles.
- Throughput: one read per SETTLE+1 cycles under continuous demand. There are no idle cycles between RESP and the next WAIT.
- `mux_sel` is stable for ≥SETTLE full cycles before capture, so SETTLE×period must exceed the mux tree delay.
- `rsp_data` holds its value until the next capture.

## Structure
- Package `regread_pkg`:
  - state enum `rr_state_t` {IDLE, WAIT, RESP}
  - constants `NREGS`=32, `DATA_W`=64, `ADDR_W`=5
- Sub-module `rr_arbiter`:
  - parameter `NREQ`
  - inputs `clk`, `reset`, `req`, `advance`
  - output one-hot `grant`
  - owns `ptr`; `advance` is asserted on accept
- Top-level: FSM, counter, `owner`, `mux_sel`/`rsp_data` registers.

## Test plan
- Single request, `SETTLE`=2: `req_valid[1]`=1 with addr 5 at T, mux model returns `64'hA5` for index 5. Expect `req_ready[1]` at T, `mux_sel`=5 at T+1, `rsp_valid[1]`=1 and `rsp_data`=`64'hA5` at T+3.
- Contention, all four requesting from reset: grants go 0,1,2,3,0. Expect one response every 3 cycles, `busy` high in every WAIT cycle, and `rsp_valid` owner matching the grant order.
- Fairness: requester 0 continuously valid, requester 2 asserts once. Expect requester 2 granted immediately after the current grant to 0, never starved.
- Back-to-back: `req_valid[3]` held high with changing addrs 0, 31, 17. Expect accept in every RESP cycle, `rsp_data` 0 for addr 31, and correct data for the others.
- Reset mid-WAIT: assert `reset` for one cycle during WAIT. Expect no `rsp_valid`, all outputs at reset values, and next grant starting at requester 0.
- `SETTLE`=1 build: latency from accept to response is 2 cycles. Check that `mux_data` sampled one cycle after a `mux_sel` change is captured.
